// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780 LCD controller
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam int INIT_LEN = 4;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    localparam int LCD_ON_BIT = 31;
    localparam int LCD_RS_BIT = 10;
    localparam int LCD_RW_BIT = 9;
    localparam int LCD_EN_BIT = 8;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT  = 8'h03;

    // Clear and home commands need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

    function automatic logic [31:0] pack_lcd_reg(input logic on, input logic rs,
                                                 input logic en, input logic [7:0] data);
        logic [31:0] r;
        r             = '0;
        r[LCD_ON_BIT] = on;
        r[LCD_RS_BIT] = rs;
        r[LCD_RW_BIT] = 1'b0;
        r[LCD_EN_BIT] = en;
        r[7:0]        = data;
        return r;
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// rtl/lcd_hd44780_ctrl_if.sv - valid/ready byte write port into the LCD controller
interface lcd_hd44780_ctrl_if;
    logic       wr_vld;
    logic       wr_rdy;
    logic       wr_rs;
    logic [7:0] wr_data;

    modport master (output wr_vld, output wr_rs, output wr_data, input  wr_rdy);
    modport slave  (input  wr_vld, input  wr_rs, input  wr_data, output wr_rdy);
endinterface

// File: rtl/lcd_wr_fifo.sv
// rtl/lcd_wr_fifo.sv - synchronous FIFO holding {rs, data} entries for the LCD controller
module lcd_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit on each pointer distinguishes full from empty
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 character LCD controller with init sequence and write FIFO
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP    = 750000,
    parameter int T_SU       = 2,
    parameter int T_EN       = 12,
    parameter int T_HOLD     = 2,
    parameter int T_EXEC     = 2000,
    parameter int T_LONG     = 80000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    lcd_hd44780_ctrl_if.slave     wr,
    output logic                  o_busy,
    output logic                  o_lcd_on,
    output logic                  o_lcd_rs,
    output logic                  o_lcd_rw,
    output logic                  o_lcd_en,
    output logic [7:0]            o_lcd_data,
    output logic [31:0]           o_lcd_reg
);
    localparam logic [31:0] C_PWRUP = 32'(T_PWRUP - 1);
    localparam logic [31:0] C_SU    = 32'(T_SU - 1);
    localparam logic [31:0] C_EN    = 32'(T_EN - 1);
    localparam logic [31:0] C_HOLD  = 32'(T_HOLD - 1);
    localparam logic [31:0] C_EXEC  = 32'(T_EXEC - 1);
    localparam logic [31:0] C_LONG  = 32'(T_LONG - 1);

    lcd_state_e  state;
    logic [31:0] cnt;
    logic [2:0]  init_idx;
    logic        init_done;
    logic        cur_rs;
    logic [7:0]  cur_data;
    logic [8:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    lcd_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (wr.wr_vld),
        .i_data  ({wr.wr_rs, wr.wr_data}),
        .i_pop   (fifo_pop),
        .o_data  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign init_done = (init_idx >= 3'(INIT_LEN));
    assign wr.wr_rdy = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && init_done && !fifo_empty;
    assign o_busy    = (state != ST_IDLE) || !init_done || !fifo_empty;
    assign o_lcd_rw  = 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_PWRUP;
            cnt        <= C_PWRUP;
            init_idx   <= '0;
            cur_rs     <= 1'b0;
            cur_data   <= '0;
            o_lcd_on   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_data <= '0;
            o_lcd_reg  <= '0;
        end else begin
            // Pins trail the FSM by one cycle, so EN rises T_SU cycles after RS/DATA settle
            o_lcd_on   <= 1'b1;
            o_lcd_rs   <= cur_rs;
            o_lcd_en   <= (state == ST_EN_HI);
            o_lcd_data <= cur_data;
            o_lcd_reg  <= pack_lcd_reg(1'b1, cur_rs, state == ST_EN_HI, cur_data);

            if (cnt != '0) cnt <= cnt - 1'b1;

            case (state)
                ST_PWRUP: if (cnt == '0) begin
                    state    <= ST_IDLE;
                    init_idx <= '0;
                end
                ST_IDLE: if (!init_done) begin
                    cur_rs   <= 1'b0;
                    cur_data <= INIT_ROM[init_idx[1:0]];
                    init_idx <= init_idx + 1'b1;
                    state    <= ST_SETUP;
                    cnt      <= C_SU;
                end else if (!fifo_empty) begin
                    {cur_rs, cur_data} <= fifo_dout;
                    state    <= ST_SETUP;
                    cnt      <= C_SU;
                end
                ST_SETUP: if (cnt == '0) begin
                    state <= ST_EN_HI;
                    cnt   <= C_EN;
                end
                ST_EN_HI: if (cnt == '0) begin
                    state <= ST_HOLD;
                    cnt   <= C_HOLD;
                end
                ST_HOLD: if (cnt == '0) begin
                    state <= ST_WAIT;
                    cnt   <= is_long_cmd(cur_rs, cur_data) ? C_LONG : C_EXEC;
                end
                ST_WAIT: if (cnt == '0) state <= ST_IDLE;
                default: begin
                    state <= ST_PWRUP;
                    cnt   <= C_PWRUP;
                end
            endcase
        end
    end
endmodule

// File: doc/lcd_hd44780_ctrl.md
# lcd_hd44780_ctrl

HD44780-style character LCD controller on the CPU's memory-mapped IO output side. Accepts command/data bytes through a valid/ready write port and buffers them in a small FIFO. Replays each byte onto the LCD pins with programmable setup, enable-pulse, hold and execution-wait timing, and runs a fixed power-up initialisation sequence after reset. Also drives a packed 32-bit mirror in the same bit layout as the core's LCD output register, so it can feed the board LCD pins directly.

## Interface
- `T_PWRUP`, 750000: power-up wait after reset, in cycles.
- `T_SU`, 2: RS/DATA setup before EN rises, in cycles.
- `T_EN`, 12: EN high width, in cycles.
- `T_HOLD`, 2: RS/DATA hold after EN falls, in cycles.
- `T_EXEC`, 2000: execution wait for normal commands and data, in cycles.
- `T_LONG`, 80000: execution wait for clear/home commands, in cycles.
- `FIFO_DEPTH`, 4: write FIFO entries; must be a power of two, ≥ 2.
- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  reset, **synchronous, active-high**.
- `i_wr_vld`  in  1  write request.
- `o_wr_rdy`  out  1  FIFO not full.
- `i_wr_rs`  in  1  0 = command, 1 = data.
- `i_wr_data`  in  8  byte to send.
- `o_busy`  out  1  high when init is pending, FIFO is non-empty, or state ≠ IDLE.
- `o_lcd_on`  out  1  LCD power/backlight enable.
- `o_lcd_rs`  out  1  register select.
- `o_lcd_rw`  out  1  always 0 (write-only).
- `o_lcd_en`  out  1  enable strobe.
- `o_lcd_data`  out  8  data bus.
- `o_lcd_reg`  out  32  packed mirror: [31]=ON, [10]=RS, [9]=RW, [8]=EN, [7:0]=DATA, all other bits 0.

## Operation
- Write handshake:
  - A write is accepted on a cycle where `i_wr_vld && o_wr_rdy`; `{rs, data}` is pushed into the FIFO.
  - Writes are accepted during init.
  - `o_wr_rdy` is `!full`, derived from registered pointers. A push and a pop in the same cycle are both legal.
- FSM states: PWRUP, IDLE, SETUP, EN_HI, HOLD, WAIT.
- Every timed state loads a down-counter with N−1 on entry and exits when the counter reaches 0, so the state lasts exactly N cycles.
- PWRUP: lasts `T_PWRUP` cycles, then goes to IDLE with the init index at 0.
- IDLE, source priority:
  - If init index < 4, take `INIT_ROM[index]` with rs=0 and increment the index.
  - Otherwise, if the FIFO is non-empty, pop it.
  - Otherwise, stay in IDLE.
  - The taken entry is latched into `cur_rs`/`cur_data`, then go to SETUP.
- INIT_ROM contents, in order: 0x38, 0x0C, 0x01, 0x06.
- SETUP (`T_SU` cycles), EN_HI (`T_EN` cycles, EN=1), HOLD (`T_HOLD` cycles), then WAIT.
- WAIT length:
  - `T_LONG` cycles if `cur_rs==0` and `cur_data ∈ {0x01, 0x02, 0x03}`.
  - Otherwise `T_EXEC` cycles.
  - Then return to IDLE.
- RS and DATA drive the latched values from SETUP entry through the end of HOLD, and stay held until the next SETUP entry.
- All pin outputs and `o_lcd_reg` are registered.

## Timing
- Reset values:
  - `o_lcd_on`, `o_lcd_rs`, `o_lcd_rw`, `o_lcd_en`, `o_lcd_data`, `o_lcd_reg` = 0.
  - `o_wr_rdy` = 1.
  - `o_busy` = 1.
  - FIFO empty, init index 0, state PWRUP.
- `o_lcd_on` goes to 1 on the first cycle after `i_rst` deasserts and stays at 1.
- Latency, when idle and init is done:
  - A write accepted at edge k gives a pop/latch at k+1.
  - RS/DATA are valid from k+2.
  - EN rises at k+2+`T_SU`.
- Back-to-back entries: a full transaction spans `T_SU+T_EN+T_HOLD+wait`, plus 1 IDLE cycle.
- When the FIFO is full with a simultaneous pop, `o_wr_rdy` rises one cycle after the pop.
- Reset asserted mid-transaction:
  - On the next edge EN=0, the FIFO is flushed, and the FSM returns to PWRUP with a full `T_PWRUP` wait.
  - The init sequence reruns.
- `o_busy` falls only when the FSM is in IDLE, init is done and the FIFO is empty.

## Structure
- Package `lcd_pkg` holds:
  - the `lcd_state_e` enum;
  - the INIT_ROM constant array;
  - the `o_lcd_reg` bit positions (`LCD_ON_BIT=31`, `LCD_RS_BIT=10`, `LCD_RW_BIT=9`, `LCD_EN_BIT=8`);
  - the clear/home opcode constants.
- One sub-module: `lcd_wr_fifo`, a synchronous 9-bit FIFO of `FIFO_DEPTH` entries with push, pop, full and empty.

## Test plan
Bench parameters: `T_PWRUP=20`, `T_SU=2`, `T_EN=4`, `T_HOLD=2`, `T_EXEC=10`, `T_LONG=40`, `FIFO_DEPTH=4`.
1. **Reset release:**
   - `o_busy=1`.
   - After 20 cycles, four EN pulses with rs=0 carry 0x38, 0x0C, 0x01, 0x06.
   - The gap after 0x01 is 40 cycles; the gap after the others is 10 cycles.
   - `o_busy` then falls.
2. **Single data write after init** (rs=1, 0x41):
   - EN is high for exactly 4 cycles, rising 2 cycles after RS/DATA change.
   - `o_lcd_reg=0x8000_0541` while EN is high and `0x8000_0441` during HOLD.
3. **Burst of 5 writes during PWRUP:**
   - 4 are accepted, then `o_wr_rdy=0`.
   - After init, the bytes are emitted in order; `o_wr_rdy` returns to 1 one cycle after the first pop.
4. **Command 0x02, then 0x80:**
   - WAIT after 0x02 lasts 40 cycles; WAIT after 0x80 lasts 10 cycles.
   - rs=1 with data 0x01 also waits 10 cycles.
5. **`i_rst` pulsed during EN_HI with 2 entries queued:**
   - Next cycle: EN=0, `o_wr_rdy=1`, FIFO empty.
   - The init sequence restarts after 20 cycles.
   - The queued bytes are never emitted.
